// File: rtl/dmem_arbiter_pkg.sv
// dmem_arbiter_pkg: shared constants for the data-memory arbiter.
//   CPU_WIDTH              default address/data width of the core
//   DMEM_ARB_NONE/CPU/DMA  2-bit encodings of the last-grant state
//   DMEM_ARB_STARVE_LIMIT  default number of consecutive DMA denials tolerated
package dmem_arbiter_pkg;

    localparam int CPU_WIDTH = 32;

    localparam logic [1:0] DMEM_ARB_NONE = 2'd0;
    localparam logic [1:0] DMEM_ARB_CPU  = 2'd1;
    localparam logic [1:0] DMEM_ARB_DMA  = 2'd2;

    localparam int DMEM_ARB_STARVE_LIMIT = 4;

    // Encode the winner of a cycle into the last-grant state.
    function automatic logic [1:0] arb_winner(input logic cpu_gnt, input logic dma_gnt);
        if (cpu_gnt)      return DMEM_ARB_CPU;
        else if (dma_gnt) return DMEM_ARB_DMA;
        else              return DMEM_ARB_NONE;
    endfunction

endpackage

// File: rtl/dmem_arb_core.sv
// dmem_arb_core: grant decision for the shared data memory.
//   Default build : fixed CPU priority; a DMA request denied STARVE_LIMIT
//                   cycles in a row wins the next conflict.
//   DMEM_ARB_RR_EN: round-robin; on a conflict the port that did not win
//                   last cycle wins (CPU if nobody won last cycle).
// Ports:
//   clk, rstn          clock, asynchronous active-low reset
//   cpu_req, dma_req   access requests
//   cpu_gnt, dma_gnt   combinational grants, mutually exclusive
//   last_gnt           state: winner of the previous cycle (NONE/CPU/DMA)
// Handshake: a requester holds req (and its command) high until it sees gnt
// in the same cycle; the access happens in that cycle.
module dmem_arb_core
    import dmem_arbiter_pkg::*;
#(
    parameter int STARVE_LIMIT = DMEM_ARB_STARVE_LIMIT
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       cpu_req,
    input  logic       dma_req,
    output logic       cpu_gnt,
    output logic       dma_gnt,
    output logic [1:0] last_gnt
);

    logic dma_priority;

`ifdef DMEM_ARB_RR_EN
    // Alternate on conflict: DMA only has priority right after a CPU win.
    assign dma_priority = (last_gnt == DMEM_ARB_CPU);
`else
    localparam int CW = $clog2(STARVE_LIMIT + 1);

    logic [CW-1:0] starve_cnt;

    assign dma_priority = (starve_cnt == CW'(STARVE_LIMIT));

    // Counts consecutive denied DMA cycles; any cycle where DMA is granted
    // or not requesting clears it.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            starve_cnt <= '0;
        end else if (dma_req && !dma_gnt) begin
            if (!dma_priority) starve_cnt <= starve_cnt + 1'b1;
        end else begin
            starve_cnt <= '0;
        end
    end
`endif

    assign cpu_gnt = cpu_req && !(dma_req && dma_priority);
    assign dma_gnt = dma_req && !cpu_gnt;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) last_gnt <= DMEM_ARB_NONE;
        else       last_gnt <= arb_winner(cpu_gnt, dma_gnt);
    end

endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares the single-port data memory between the MEM stage
// (CPU port) and a DMA/loader port. One access per cycle; read data is
// registered and returned the cycle after the grant.
// Configuration macro: DMEM_ARB_RR_EN selects round-robin arbitration
// (default is fixed CPU priority with a DMA starvation limit).
// Ports:
//   clk, rstn                       clock, asynchronous active-low reset
//   cpu_req/we/addr/wdata           CPU request, held until cpu_gnt
//   cpu_gnt, cpu_stall              grant this cycle, req & ~gnt
//   cpu_rvalid, cpu_rdata           registered load response
//   dma_req/we/addr/wdata           DMA request, held until dma_gnt
//   dma_gnt                         grant this cycle
//   dma_rvalid, dma_rdata           registered read response
//   mem_addr/wdata/write_en/read_en memory command from the granted port
//   mem_rdata                       combinational read data from memory
//   dbg_last_gnt                    arbiter state (winner of previous cycle)
module dmem_arbiter
    import dmem_arbiter_pkg::*;
#(
    parameter int AW           = CPU_WIDTH,
    parameter int DW           = CPU_WIDTH,
    parameter int STARVE_LIMIT = DMEM_ARB_STARVE_LIMIT
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    output logic          cpu_gnt,
    output logic          cpu_stall,
    output logic          cpu_rvalid,
    output logic [DW-1:0] cpu_rdata,
    input  logic          dma_req,
    input  logic          dma_we,
    input  logic [AW-1:0] dma_addr,
    input  logic [DW-1:0] dma_wdata,
    output logic          dma_gnt,
    output logic          dma_rvalid,
    output logic [DW-1:0] dma_rdata,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    output logic          mem_write_en,
    output logic          mem_read_en,
    input  logic [DW-1:0] mem_rdata,
    output logic [1:0]    dbg_last_gnt
);

    logic cpu_rd;
    logic dma_rd;

    dmem_arb_core #(
        .STARVE_LIMIT(STARVE_LIMIT)
    ) u_core (
        .clk      (clk),
        .rstn     (rstn),
        .cpu_req  (cpu_req),
        .dma_req  (dma_req),
        .cpu_gnt  (cpu_gnt),
        .dma_gnt  (dma_gnt),
        .last_gnt (dbg_last_gnt)
    );

    assign cpu_stall = cpu_req && !cpu_gnt;
    assign cpu_rd    = cpu_gnt && !cpu_we;
    assign dma_rd    = dma_gnt && !dma_we;

    // Command mux: the memory sees zeros when nothing is granted.
    always_comb begin
        mem_addr     = '0;
        mem_wdata    = '0;
        mem_write_en = 1'b0;
        mem_read_en  = 1'b0;
        if (cpu_gnt) begin
            mem_addr     = cpu_addr;
            mem_wdata    = cpu_wdata;
            mem_write_en = cpu_we;
            mem_read_en  = !cpu_we;
        end else if (dma_gnt) begin
            mem_addr     = dma_addr;
            mem_wdata    = dma_wdata;
            mem_write_en = dma_we;
            mem_read_en  = !dma_we;
        end
    end

    // Read responses: rvalid pulses once per granted read, rdata holds
    // until the next read on the same port.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cpu_rvalid <= 1'b0;
            cpu_rdata  <= '0;
            dma_rvalid <= 1'b0;
            dma_rdata  <= '0;
        end else begin
            cpu_rvalid <= cpu_rd;
            dma_rvalid <= dma_rd;
            if (cpu_rd) cpu_rdata <= mem_rdata;
            if (dma_rd) dma_rdata <= mem_rdata;
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
module tb_dmem_arbiter;

  localparam int W     = 32;
  localparam int LIMIT = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rstn;
  always #5 clk = ~clk;

  logic         cpu_req, cpu_we, dma_req, dma_we;
  logic [W-1:0] cpu_addr, cpu_wdata, dma_addr, dma_wdata;
  logic         cpu_gnt, cpu_stall, cpu_rvalid, dma_gnt, dma_rvalid;
  logic [W-1:0] cpu_rdata, dma_rdata, mem_addr, mem_wdata, mem_rdata;
  logic         mem_write_en, mem_read_en;
  logic [1:0]   dbg_last_gnt;

  dmem_arbiter #(.AW(W), .DW(W), .STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .rstn(rstn),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(cpu_gnt), .cpu_stall(cpu_stall), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
    .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
    .dma_gnt(dma_gnt), .dma_rvalid(dma_rvalid), .dma_rdata(dma_rdata),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_write_en(mem_write_en),
    .mem_read_en(mem_read_en), .mem_rdata(mem_rdata), .dbg_last_gnt(dbg_last_gnt)
  );

  // Environment memory (64 words, combinational read, write at posedge).
  logic [W-1:0] dmem [0:63];
  assign mem_rdata = dmem[mem_addr[7:2]];
  always @(posedge clk) if (mem_write_en) dmem[mem_addr[7:2]] <= mem_wdata;

  // ---------------- reference model ----------------
  logic [W-1:0] ref_mem [0:63];
  int           m_last;      // 0 none, 1 cpu, 2 dma
  int           m_denied;    // consecutive denied DMA cycles, capped at LIMIT
  logic         exp_cpu_rv, exp_dma_rv;
  logic [W-1:0] exp_cpu_rdata, exp_dma_rdata;
  logic [W-1:0] exp_q[$];    // expected CPU load data, in order

  int n_cmp = 0;
  int n_err = 0;

  // sampled actuals of the last cycle (for table checks)
  logic         s_cg, s_dg, s_we, s_re;
  logic [W-1:0] s_addr;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_last = 0; m_denied = 0;
    exp_cpu_rv = 1'b0; exp_dma_rv = 1'b0;
    exp_cpu_rdata = '0; exp_dma_rdata = '0;
    exp_q.delete();
  endtask

  // ---------------- driver: one clock cycle ----------------
  // Entered 1 time unit after a posedge; returns 1 time unit after the next.
  task automatic cycle(input logic cr, input logic cw, input logic [W-1:0] ca, input logic [W-1:0] cd,
                       input logic dr, input logic dw, input logic [W-1:0] da, input logic [W-1:0] dd);
    logic         dma_pri, e_cg, e_dg;
    logic [W-1:0] e_addr;
    cpu_req = cr; cpu_we = cw; cpu_addr = ca; cpu_wdata = cd;
    dma_req = dr; dma_we = dw; dma_addr = da; dma_wdata = dd;
    #2;
`ifdef DMEM_ARB_RR_EN
    dma_pri = (m_last == 1);
`else
    dma_pri = (m_denied >= LIMIT);
`endif
    e_dg   = dr && (!cr || dma_pri);
    e_cg   = cr && !e_dg;
    e_addr = e_cg ? ca : (e_dg ? da : '0);
    chk("cpu_gnt", W'(cpu_gnt), W'(e_cg));
    chk("dma_gnt", W'(dma_gnt), W'(e_dg));
    chk("cpu_stall", W'(cpu_stall), W'(cr && !e_cg));
    chk("mem_addr", mem_addr, e_addr);
    chk("mem_write_en", W'(mem_write_en), W'((e_cg && cw) || (e_dg && dw)));
    chk("mem_read_en", W'(mem_read_en), W'((e_cg && !cw) || (e_dg && !dw)));
    if (e_cg && cw) chk("mem_wdata_cpu", mem_wdata, cd);
    if (e_dg && dw) chk("mem_wdata_dma", mem_wdata, dd);
    chk("last_gnt", W'(dbg_last_gnt), W'(m_last));
    chk("cpu_rvalid", W'(cpu_rvalid), W'(exp_cpu_rv));
    chk("dma_rvalid", W'(dma_rvalid), W'(exp_dma_rv));
    if (cpu_rvalid) begin
      if (exp_q.size() == 0) chk("cpu_rdata_queue", 32'd1, 32'd0);
      else exp_cpu_rdata = exp_q.pop_front();
    end
    chk("cpu_rdata", cpu_rdata, exp_cpu_rdata);
    chk("dma_rdata", dma_rdata, exp_dma_rdata);
    s_cg = cpu_gnt; s_dg = dma_gnt; s_addr = mem_addr; s_we = mem_write_en; s_re = mem_read_en;
    @(posedge clk);
    exp_cpu_rv = e_cg && !cw;
    exp_dma_rv = e_dg && !dw;
    if (exp_cpu_rv) exp_q.push_back(ref_mem[ca[7:2]]);
    if (exp_dma_rv) exp_dma_rdata = ref_mem[da[7:2]];
    if (e_cg && cw) ref_mem[ca[7:2]] = cd;
    if (e_dg && dw) ref_mem[da[7:2]] = dd;
    m_last   = e_cg ? 1 : (e_dg ? 2 : 0);
    m_denied = (dr && !e_dg) ? ((m_denied < LIMIT) ? m_denied + 1 : LIMIT) : 0;
    #1;
  endtask

  task automatic idle();
    cycle(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_gnts"}, W'({cpu_gnt, dma_gnt, cpu_stall}), '0);
    chk({tag, "_rvalid"}, W'({cpu_rvalid, dma_rvalid}), '0);
    chk({tag, "_cpu_rdata"}, cpu_rdata, '0);
    chk({tag, "_dma_rdata"}, dma_rdata, '0);
    chk({tag, "_mem_en"}, W'({mem_write_en, mem_read_en}), '0);
    chk({tag, "_mem_addr"}, mem_addr, '0);
    chk({tag, "_last_gnt"}, W'(dbg_last_gnt), '0);
  endtask

  // ---------------- table vectors ----------------
  typedef struct {
    logic cr, cw; logic [W-1:0] ca, cd;
    logic dr, dw; logic [W-1:0] da, dd;
    logic e_cg, e_dg; logic [W-1:0] e_addr; logic e_we, e_re;
  } vec_t;
  vec_t vecs[7];

  initial begin
    logic cr, cw, dr, dw;
    logic [W-1:0] ca, cd, da, dd;
    logic exp_dma;

    vecs[0] = '{0,0,32'h0, 32'h0,        0,0,32'h0, 32'h0,        0,0,32'h0, 0,0};
    vecs[1] = '{1,0,32'h10,32'h0,        0,0,32'h0, 32'h0,        1,0,32'h10,0,1};
    vecs[2] = '{0,0,32'h0, 32'h0,        1,1,32'h20,32'hCAFEF00D, 0,1,32'h20,1,0};
    vecs[3] = '{0,0,32'h0, 32'h0,        0,0,32'h0, 32'h0,        0,0,32'h0, 0,0};
    vecs[4] = '{1,1,32'h30,32'h11112222, 1,0,32'h40,32'h0,        1,0,32'h30,1,0};
    vecs[5] = '{0,0,32'h0, 32'h0,        1,0,32'h40,32'h0,        0,1,32'h40,0,1};
    vecs[6] = '{0,0,32'h0, 32'h0,        0,0,32'h0, 32'h0,        0,0,32'h0, 0,0};

    for (int i = 0; i < 64; i++) begin
      dmem[i]    = 32'hA5000000 ^ (i * 32'h01010101);
      ref_mem[i] = 32'hA5000000 ^ (i * 32'h01010101);
    end
    dmem[4] = 32'hDEADBEEF; ref_mem[4] = 32'hDEADBEEF;
    model_reset();

    // reset state
    rstn = 1'b0;
    cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0;
    dma_req = 0; dma_we = 0; dma_addr = '0; dma_wdata = '0;
    repeat (2) @(posedge clk);
    #1 check_all_zero("reset");
    @(negedge clk) rstn = 1'b1;
    @(posedge clk); #1;

    // table-driven single cycles
    for (int i = 0; i < 7; i++) begin
      cycle(vecs[i].cr, vecs[i].cw, vecs[i].ca, vecs[i].cd, vecs[i].dr, vecs[i].dw, vecs[i].da, vecs[i].dd);
      chk($sformatf("vec%0d_cpu_gnt", i), W'(s_cg), W'(vecs[i].e_cg));
      chk($sformatf("vec%0d_dma_gnt", i), W'(s_dg), W'(vecs[i].e_dg));
      chk($sformatf("vec%0d_addr", i), s_addr, vecs[i].e_addr);
      chk($sformatf("vec%0d_en", i), W'({s_we, s_re}), W'({vecs[i].e_we, vecs[i].e_re}));
    end

    // CPU load of a known word
    cycle(1, 0, 32'h10, '0, 0, 0, '0, '0);
    chk("load10_rvalid", W'(cpu_rvalid), 32'd1);
    chk("load10_rdata", cpu_rdata, 32'hDEADBEEF);
    idle();

    // DMA write then CPU load of the same address on the next cycle
    cycle(0, 0, '0, '0, 1, 1, 32'h20, 32'h12345678);
    cycle(1, 0, 32'h20, '0, 0, 0, '0, '0);
    chk("raw20_rdata", cpu_rdata, 32'h12345678);
    idle();

    // both ports requesting continuously
    idle();
    for (int k = 0; k < 6; k++) begin
      cycle(1, 0, 32'h8, '0, 1, 0, 32'hC, '0);
`ifdef DMEM_ARB_RR_EN
      exp_dma = (k % 2 == 1);
`else
      exp_dma = (k == 4);
`endif
      chk($sformatf("hold%0d_dma_gnt", k), W'(s_dg), W'(exp_dma));
      chk($sformatf("hold%0d_cpu_gnt", k), W'(s_cg), W'(!exp_dma));
    end
    idle();

    // reset right after a DMA read grant drops the pending response
    cycle(0, 0, '0, '0, 1, 0, 32'h44, '0);
    chk("pre_reset_dma_rvalid", W'(dma_rvalid), 32'd1);
    cpu_req = 0; dma_req = 0; cpu_we = 0; dma_we = 0;
    rstn = 1'b0;
    #1 check_all_zero("midreset");
    model_reset();
    @(posedge clk); #1 check_all_zero("midreset2");
    @(negedge clk) rstn = 1'b1;
    @(posedge clk); #1;

    // ten idle cycles
    for (int k = 0; k < 10; k++) idle();

    // randomized traffic, requests held until granted
    cr = 0; dr = 0; cw = 0; dw = 0; ca = '0; cd = '0; da = '0; dd = '0;
    s_cg = 0; s_dg = 0;
    for (int k = 0; k < 400; k++) begin
      if (!cr || s_cg) begin
        cr = ($urandom_range(0, 2) != 0);
        cw = $urandom_range(0, 1);
        ca = W'($urandom_range(0, 63)) << 2;
        cd = $urandom;
      end
      if (!dr || s_dg) begin
        dr = ($urandom_range(0, 2) != 0);
        dw = $urandom_range(0, 1);
        da = W'($urandom_range(0, 63)) << 2;
        dd = $urandom;
      end
      cycle(cr, cw, ca, cd, dr, dw, da, dd);
    end
    idle();
    idle();
    chk("exp_q_drained", W'(exp_q.size()), '0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  // global time limit
  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    n_err++;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $fatal(1, "timeout");
  end

endmodule
